// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the demux4_hold destination-steering block:
//   NUM_DEST        number of destination holding registers
//   SEL_A..SEL_D    encodings of the 2-bit destination select
//   chan_state_t    per-destination state (ST_EMPTY / ST_FULL)
//   STALL_MAX       saturation value of the optional stall counter
//   sel_onehot()    select index to one-hot destination mask
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_DEST = 4;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_t;

    localparam logic [7:0] STALL_MAX = 8'd255;

    // Convert a destination select into a one-hot destination mask.
    function automatic logic [NUM_DEST-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_DEST-1:0] mask;
        case (sel)
            SEL_A:   mask = 4'b0001;
            SEL_B:   mask = 4'b0010;
            SEL_C:   mask = 4'b0100;
            SEL_D:   mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/demux_hold_chan.sv
// ---------------------------------------------------------------------------
// demux_hold_chan
// One-deep holding buffer for a single destination: a WIDTH-bit data
// register plus an EMPTY/FULL state flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         write d this cycle (only raised by the parent when can_load)
//   ack          consumer takes the held beat this cycle
//   d            beat to store
//   q            held data (keeps last value after ack)
//   valid        buffer holds an unconsumed beat
//   can_load     buffer can take a beat this cycle (empty, or being drained)
// ---------------------------------------------------------------------------
module demux_hold_chan
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             can_load
);

    chan_state_t      state_r;
    chan_state_t      state_s;
    logic [WIDTH-1:0] data_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Data register: loads on accept, otherwise holds (also across an ack).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {WIDTH{1'b0}};
        end else if (load) begin
            data_r <= d;
        end else begin
            data_r <= data_r;
        end
    end

    // Next-state logic: a load wins over an ack so a drain-and-refill
    // in the same cycle stays FULL with no bubble.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (load) begin
                    state_s = ST_FULL;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (load) begin
                    state_s = ST_FULL;
                end else if (ack) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    assign q        = data_r;
    assign valid    = (state_r == ST_FULL);
    assign can_load = (state_r == ST_EMPTY) | ack;

endmodule

// File: rtl/demux4_hold.sv
// ---------------------------------------------------------------------------
// demux4_hold
// Steers one WIDTH-bit producer beat into one of four one-deep destination
// holding registers selected by in_sel, with per-destination back-pressure.
// Optional build macro: DEMUX_STALL_CNT_EN enables the saturating stall
// counter on stall_cnt; without it stall_cnt is constant zero.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data, in_sel       producer beat and destination index (0=a..3=d)
//   in_valid, in_ready    producer handshake (in_ready is combinational)
//   out_a..out_d          destination holding registers
//   out_valid[3:0]        destination i holds an unconsumed beat
//   out_ack[3:0]          consumer i takes its beat this cycle
//   stall_cnt[7:0]        cycles with in_valid & ~in_ready (saturating)
// ---------------------------------------------------------------------------
module demux4_hold
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic [7:0]       stall_cnt
);

    logic [NUM_DEST-1:0] sel_mask_s;
    logic [NUM_DEST-1:0] can_load_s;
    logic [NUM_DEST-1:0] load_s;
    logic                accept_s;
    logic [WIDTH-1:0]    q_s [NUM_DEST];

    assign sel_mask_s = sel_onehot(in_sel);

    // Ready depends only on the selected destination; other full ones never block.
    always_comb begin
        in_ready = 1'b0;
        case (in_sel)
            SEL_A:   in_ready = can_load_s[0];
            SEL_B:   in_ready = can_load_s[1];
            SEL_C:   in_ready = can_load_s[2];
            SEL_D:   in_ready = can_load_s[3];
            default: in_ready = 1'b0;
        endcase
    end

    assign accept_s = in_valid & in_ready;
    assign load_s   = sel_mask_s & {NUM_DEST{accept_s}};

    for (genvar i = 0; i < NUM_DEST; i++) begin : g_chan
        demux_hold_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_s[i]),
            .ack      (out_ack[i]),
            .d        (in_data),
            .q        (q_s[i]),
            .valid    (out_valid[i]),
            .can_load (can_load_s[i])
        );
    end

    assign out_a = q_s[0];
    assign out_b = q_s[1];
    assign out_c = q_s[2];
    assign out_d = q_s[3];

`ifdef DEMUX_STALL_CNT_EN
    logic [7:0] stall_r;

    // Saturating count of cycles where the producer is held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= 8'd0;
        end else if (in_valid && !in_ready && (stall_r != STALL_MAX)) begin
            stall_r <= stall_r + 8'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_cnt = stall_r;
`else
    assign stall_cnt = 8'd0;
`endif

endmodule

// File: doc/demux4_hold.md
Name: demux4_hold

Overview:
- Inverse of the datapath select muxes: steers one WIDTH-bit producer beat to one of four destination holding registers, chosen by a 2-bit select.
- Each destination is an independent one-deep buffer with a valid flag and a consumer acknowledge.
- Sits between the 8-bit datapath result bus and four downstream consumers, e.g. register-write or port latches.
- Provides back-pressure per destination, so a beat is never lost or overwritten.

Parameters:
- WIDTH, 8, data width of the input beat and of each output register. Use 3 for small-data instances.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  producer beat
- in_sel  input  2  destination index: 0=a, 1=b, 2=c, 3=d
- in_valid  input  1  producer offers a beat this cycle
- in_ready  output  1  beat accepted this cycle when in_valid is also high
- out_a, out_b, out_c, out_d  output  WIDTH each  destination holding registers
- out_valid  output  4  bit i set while destination i holds an unconsumed beat
- out_ack  input  4  bit i: consumer i takes its beat this cycle
- stall_cnt  output  8  optional statistic, see Optional Feature

Behaviour:
- Reset (async assert, release synchronous to clk):
  - out_a..out_d = 0, out_valid = 4'b0000, stall_cnt = 0.
  - Reset mid-operation discards all held beats immediately.
- Per-destination FSM, states EMPTY and FULL:
  - EMPTY -> FULL on accept to this index.
  - FULL -> EMPTY on out_ack[i] with no accept to i.
  - FULL -> FULL on simultaneous out_ack[i] and accept to i. The new beat replaces the old one with no bubble.
  - out_ack[i] while EMPTY is ignored.
- in_ready is combinational: in_ready = ~out_valid[in_sel] | out_ack[in_sel].
  - It depends only on the selected destination. Other full destinations do not block.
- accept = in_valid & in_ready.
  - On accept, the selected register loads in_data at the clock edge.
  - The beat is visible with out_valid set on the next cycle. Latency is 1 cycle.
- Non-selected destinations hold their data and state. Acks to other indices in the same cycle are processed independently.
- Output registers keep their last data after ack. Only out_valid clears. Data is undefined-by-contract while invalid.
- in_sel and in_data are ignored when in_valid = 0.
- No combinational path from in_data to any output.

Optional Feature:
- Macro: DEMUX_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with in_valid & ~in_ready.
  - It saturates at 255 and never wraps.
  - It is cleared only by reset.
- Undefined: stall_cnt is tied to 8'd0 and no counter flops are built.
- The port list is identical in both builds.

Decomposition:
- Shared package (demux_pkg):
  - NUM_DEST = 4.
  - Select encodings SEL_A..SEL_D = 2'd0..2'd3.
  - Channel state encodings ST_EMPTY = 1'b0, ST_FULL = 1'b1.
  - STALL_MAX = 8'd255.
- Sub-module demux_hold_chan, instantiated four times. It holds one WIDTH register plus valid flag.
  - Inputs: load, ack, d.
  - Outputs: q, valid, can_load.
- The top level does select decode, in_ready muxing and the optional counter.

Test Plan:
- Reset then single write: in_sel=2, in_data=8'hA5, in_valid=1 for one cycle -> next cycle out_c=8'hA5, out_valid=4'b0100; other outputs 0.
- Back-pressure: out_b full with 8'h11 and no ack; offer in_sel=1, in_data=8'h22 -> in_ready=0, out_b stays 8'h11. Assert out_ack[1] -> in_ready=1 that cycle, next cycle out_b=8'h22, out_valid[1]=1.
- Independence: out_a full, offer in_sel=3, in_data=8'h3C -> in_ready=1, next cycle out_d=8'h3C, out_valid=4'b1001.
- Ack on empty plus multi-ack: out_ack=4'b1111 with only out_a, out_d full -> out_valid=4'b0000 next cycle; no other state changes.
- Async reset mid-stream: rst_n low between clock edges with out_valid=4'b1011 -> out_valid=0 and outputs 0 immediately, without waiting for a clock edge.
- With DEMUX_STALL_CNT_EN: hold a blocked offer for 300 cycles -> stall_cnt reads 255 and stays. Without the macro -> stall_cnt=0 throughout.
